sr_latch_ctrl: RTL

Clocked sequencer that shares one cross-coupled `sr` latch between two requesters, A and B. Each requester asks for a set or a clear operation. The block arbitrates round-robin between them and drives active-low, fixed-width set/reset pulses into the latch, never asserting both at once. After the pulse it waits a settle time and optionally checks the latch output before acknowledging. It sits between synchronous control logic and the asynchronous latch primitive.

---
 rtl/sr_latch_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sr_latch_ctrl.sv
// Purpose : round-robin sequencer sharing one cross-coupled SR latch between requesters A and B.
// Latency : grant edge to ack is PULSE_W+SETTLE_W cycles (illegal set+clr request acks in the cycle after grant).
// Backpr. : requests are levels held until ack; the loser of a tie waits for the next IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_set_a/req_clr_a   requester A operation request (level), ack_a one-cycle completion
//   req_set_b/req_clr_b   requester B operation request (level), ack_b one-cycle completion
//   clr_err               synchronous clear of the sticky err flags
//   latch_ns/latch_nr     registered active-low set/reset drive into the latch
//   latch_q               latch output feedback
//   busy                  high whenever the sequencer is not IDLE
//   err[1:0]              sticky: [0] illegal request, [1] verify mismatch
//
// Optional feature macro: SR_LATCH_CTRL_VERIFY_EN enables the latch_q readback check.
module sr_latch_ctrl #(
    parameter int PULSE_W  = 2,
    parameter int SETTLE_W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_set_a,
    input  logic       req_clr_a,
    output logic       ack_a,
    input  logic       req_set_b,
    input  logic       req_clr_b,
    output logic       ack_b,
    input  logic       clr_err,
    output logic       latch_ns,
    output logic       latch_nr,
    input  logic       latch_q,
    output logic       busy,
    output logic [1:0] err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] LP_PULSE  = 8'(PULSE_W);
    localparam logic [7:0] LP_SETTLE = 8'(SETTLE_W);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_ptr_b, w_ptr_b_nxt;     // round-robin pointer: 0 = A has priority
    logic       r_gnt_b, w_gnt_b_nxt;     // requester owning the current operation
    logic       r_exp_q, w_exp_q_nxt;     // q value the latch should hold afterwards
    logic       r_ns, w_ns_nxt;
    logic       r_nr, w_nr_nxt;
    logic [1:0] r_err;

    logic       w_pend_a, w_pend_b, w_sel_b, w_sel_set, w_sel_clr;
    logic       w_err_ill, w_chk, w_err_ver;

    assign w_pend_a  = req_set_a | req_clr_a;
    assign w_pend_b  = req_set_b | req_clr_b;
    // B wins when it is the only one pending, or both pend and the pointer favours B.
    assign w_sel_b   = w_pend_b & (~w_pend_a | r_ptr_b);
    assign w_sel_set = w_sel_b ? req_set_b : req_set_a;
    assign w_sel_clr = w_sel_b ? req_clr_b : req_clr_a;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_b_nxt = r_ptr_b;
        w_gnt_b_nxt = r_gnt_b;
        w_exp_q_nxt = r_exp_q;
        w_ns_nxt    = r_ns;
        w_nr_nxt    = r_nr;
        w_err_ill   = 1'b0;
        w_chk       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_a | w_pend_b) begin
                    w_gnt_b_nxt = w_sel_b;
                    w_ptr_b_nxt = ~w_sel_b;
                    if (w_sel_set & w_sel_clr) begin
                        // Conflicting request: no pulse, just flag and acknowledge.
                        w_err_ill   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_exp_q_nxt = w_sel_set;
                        w_ns_nxt    = ~w_sel_set;
                        w_nr_nxt    = ~w_sel_clr;
                        w_cnt_nxt   = LP_PULSE;
                        w_state_nxt = PULSE;
                    end
                end
            end
            PULSE: begin
                if (r_cnt <= 8'd1) begin
                    w_ns_nxt = 1'b1;
                    w_nr_nxt = 1'b1;
                    if (LP_SETTLE == 8'd0) begin
                        w_chk       = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt   = LP_SETTLE;
                        w_state_nxt = SETTLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            SETTLE: begin
                if (r_cnt <= 8'd1) begin
                    w_chk       = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The readback is taken on the edge that enters DONE so a mismatch flag
    // becomes visible in the same cycle as the ack.
`ifdef SR_LATCH_CTRL_VERIFY_EN
    assign w_err_ver = w_chk & (latch_q != r_exp_q);
`else
    logic w_unused;
    assign w_unused  = latch_q ^ r_exp_q ^ w_chk;
    assign w_err_ver = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_ptr_b <= 1'b0;
            r_gnt_b <= 1'b0;
            r_exp_q <= 1'b0;
            r_ns    <= 1'b1;
            r_nr    <= 1'b1;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr_b <= w_ptr_b_nxt;
            r_gnt_b <= w_gnt_b_nxt;
            r_exp_q <= w_exp_q_nxt;
            r_ns    <= w_ns_nxt;
            r_nr    <= w_nr_nxt;
            // A flag being raised beats a simultaneous clear.
            r_err   <= (r_err & {2{~clr_err}}) | {w_err_ver, w_err_ill};
        end
    end

    assign latch_ns = r_ns;
    assign latch_nr = r_nr;
    assign busy     = (r_state != IDLE);
    assign ack_a    = (r_state == DONE) & ~r_gnt_b;
    assign ack_b    = (r_state == DONE) &  r_gnt_b;
    assign err      = r_err;

endmodule
